// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller slice.
package stopwatch_pkg;

    // Controller states; the encoding is visible on the state output port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } sw_state_t;

    // Packed time word {zm[2:0], um[3:0], zs[2:0], us[3:0]}.
    localparam int unsigned TIME_W_DEF = 14;
    localparam int unsigned US_LSB     = 0;
    localparam int unsigned ZS_LSB     = 4;
    localparam int unsigned UM_LSB     = 7;
    localparam int unsigned ZM_LSB     = 11;

    // Counting states: prescaler advances and valid may fire.
    function automatic logic is_running(input sw_state_t s);
        return (s == RUN) || (s == LAP);
    endfunction

    // Build a packed mm:ss word from its four digit fields.
    function automatic logic [TIME_W_DEF-1:0] pack_time(
        input logic [2:0] zm,
        input logic [3:0] um,
        input logic [2:0] zs,
        input logic [3:0] us
    );
        logic [TIME_W_DEF-1:0] t;
        t = '0;
        t[ZM_LSB +: 3] = zm;
        t[UM_LSB +: 4] = um;
        t[ZS_LSB +: 3] = zs;
        t[US_LSB +: 4] = us;
        return t;
    endfunction

endpackage

// File: rtl/stopwatch_btn_sync_edge.sv
// Button conditioner: 2-flop synchronizer followed by a rising-edge
// detector producing a one-cycle event per press.
module btn_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_evt
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    // Synchronize the raw level and keep one cycle of history for edge detect.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_evt = r_sync2 & ~r_prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear controller for the mm:ss stopwatch counter chain.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned TIME_W   = TIME_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_start,
    input  logic              btn_reset,
    input  logic              btn_lap,
    input  logic [TIME_W-1:0] time_in,
    output logic              valid,
    output logic              fsm_reset,
    output logic [TIME_W-1:0] time_disp,
    output logic              lap_hold,
    output logic [1:0]        state
);

    localparam int unsigned   PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic w_start_evt;
    logic w_reset_evt;
    logic w_lap_evt;

    sw_state_t         r_state;
    sw_state_t         w_state_nxt;
    logic              w_take_snap;
    logic              w_clear;
    logic [PW-1:0]     r_presc;
    logic [TIME_W-1:0] r_snap;
    logic              r_fsm_reset;

    btn_sync_edge u_sync_start (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_btn   (btn_start),
        .o_evt   (w_start_evt)
    );

    btn_sync_edge u_sync_reset (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_btn   (btn_reset),
        .o_evt   (w_reset_evt)
    );

    btn_sync_edge u_sync_lap (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_btn   (btn_lap),
        .o_evt   (w_lap_evt)
    );

    // Next-state decode; priority reset > start > lap, illegal events dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_take_snap = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_evt) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_start_evt) begin
                    w_state_nxt = PAUSE;
                end else if (w_lap_evt) begin
                    w_state_nxt = LAP;
                    w_take_snap = 1'b1;
                end
            end
            LAP: begin
                if (w_start_evt)    w_state_nxt = PAUSE;
                else if (w_lap_evt) w_state_nxt = RUN;
            end
            PAUSE: begin
                if (w_reset_evt) begin
                    w_state_nxt = IDLE;
                    w_clear     = 1'b1;
                end else if (w_start_evt) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, snapshot and registered clear pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_snap      <= '0;
            r_fsm_reset <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fsm_reset <= w_clear;
            if (w_take_snap) r_snap <= time_in;
        end
    end

    // Prescaler: counts while running, holds in PAUSE, zeroed on entry to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
        end else if (w_clear) begin
            r_presc <= '0;
        end else if (is_running(r_state)) begin
            r_presc <= (r_presc == PRESC_MAX) ? '0 : r_presc + PW'(1);
        end
    end

    assign valid     = is_running(r_state) && (r_presc == PRESC_MAX);
    assign fsm_reset = r_fsm_reset;
    assign lap_hold  = (r_state == LAP);
    assign time_disp = lap_hold ? r_snap : time_in;
    assign state     = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed scoreboard bench for stopwatch_ctrl with TICK_DIV=4.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int unsigned TD  = 4;
    localparam int unsigned TW  = 14;
    localparam int unsigned BS  = 0;
    localparam int unsigned BR  = 1;
    localparam int unsigned BL  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          btn_start;
    logic          btn_reset;
    logic          btn_lap;
    logic [TW-1:0] time_in;
    logic          valid;
    logic          fsm_reset;
    logic [TW-1:0] time_disp;
    logic          lap_hold;
    logic [1:0]    state;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .TICK_DIV (TD),
        .TIME_W   (TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_start (btn_start),
        .btn_reset (btn_reset),
        .btn_lap   (btn_lap),
        .time_in   (time_in),
        .valid     (valid),
        .fsm_reset (fsm_reset),
        .time_disp (time_disp),
        .lap_hold  (lap_hold),
        .state     (state)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        sb_item_t it;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $error("FAIL sb_empty observed=%0h expected=<none>", obs);
        end else begin
            it = sb_q.pop_front();
            assert (obs === it.exp) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_btn(input int unsigned which, input logic lvl);
        case (which)
            BS:      btn_start = lvl;
            BR:      btn_reset = lvl;
            default: btn_lap   = lvl;
        endcase
    endtask

    // One-cycle press; returns one cycle later with the button released.
    task automatic pulse(input int unsigned which);
        set_btn(which, 1'b1);
        step();
        set_btn(which, 1'b0);
    endtask

    // Press and wait until the resulting state change is visible.
    task automatic press(input int unsigned which);
        pulse(which);
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TW-1:0] tv;
        int            nv;
        int            mism;

        rst       = 1'b0;
        btn_start = 1'b0;
        btn_reset = 1'b0;
        btn_lap   = 1'b0;
        tv        = pack_time(3'd1, 4'd2, 3'd3, 4'd4);
        time_in   = tv;

        // 1: reset values, then idle with no buttons
        repeat (3) step();
        sb_push("rst_state", IDLE);
        sb_push("rst_valid", 0);
        sb_push("rst_fsm_reset", 0);
        sb_push("rst_lap_hold", 0);
        sb_push("rst_time_disp", tv);
        sb_check(state);
        sb_check(valid);
        sb_check(fsm_reset);
        sb_check(lap_hold);
        sb_check(time_disp);
        rst = 1'b1;
        repeat (20) begin
            step();
            sb_push("idle_state", IDLE);
            sb_push("idle_valid", 0);
            sb_push("idle_fsm_reset", 0);
            sb_check(state);
            sb_check(valid);
            sb_check(fsm_reset);
        end
        press(BL);
        sb_push("idle_lap_ignored", IDLE);
        sb_push("idle_lap_hold", 0);
        sb_check(state);
        sb_check(lap_hold);
        press(BR);
        sb_push("idle_reset_ignored", IDLE);
        sb_push("idle_reset_no_pulse", 0);
        sb_check(state);
        sb_check(fsm_reset);

        // 2: start -> RUN two edges after sampling, valid every 4 cycles
        pulse(BS);
        step();
        sb_push("start_not_yet", IDLE);
        sb_check(state);
        step();
        sb_push("start_run", RUN);
        sb_check(state);
        for (int c = 1; c <= 12; c++) sb_push($sformatf("run_valid_c%0d", c), (c % 4 == 0));
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) step();
            sb_check(valid);
        end

        // 3: pause after two prescaler counts, resume keeps the fraction
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        step();
        step();
        sb_push("pause_state", PAUSE);
        sb_check(state);
        for (int i = 0; i < 10; i++) sb_push("pause_valid", 0);
        repeat (10) begin
            step();
            sb_check(valid);
        end
        press(BS);
        sb_push("resume_state", RUN);
        sb_check(state);
        sb_push("resume_valid_c1", 0);
        sb_push("resume_valid_c2", 1);
        sb_push("resume_valid_c3", 0);
        sb_push("resume_valid_c4", 0);
        sb_push("resume_valid_c5", 0);
        sb_push("resume_valid_c6", 1);
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) step();
            sb_check(valid);
        end

        // 4: lap freezes the display, second lap releases it
        time_in = 14'h0123;
        press(BL);
        sb_push("lap_state", LAP);
        sb_push("lap_hold", 1);
        sb_push("lap_disp", 14'h0123);
        sb_check(state);
        sb_check(lap_hold);
        sb_check(time_disp);
        time_in = 14'h0456;
        #1;
        sb_push("lap_disp_frozen", 14'h0123);
        sb_check(time_disp);
        nv = 0;
        repeat (4) begin
            step();
            nv += int'(valid);
        end
        sb_push("lap_valid_per_period", 1);
        sb_check(nv);
        press(BL);
        sb_push("unlap_state", RUN);
        sb_push("unlap_hold", 0);
        sb_push("unlap_disp", 14'h0456);
        sb_check(state);
        sb_check(lap_hold);
        sb_check(time_disp);
        time_in = 14'h0789;
        #1;
        sb_push("unlap_disp_tracks", 14'h0789);
        sb_check(time_disp);

        // start and lap together in RUN: start wins
        btn_start = 1'b1;
        btn_lap   = 1'b1;
        step();
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        step();
        step();
        sb_push("start_lap_coincide", PAUSE);
        sb_push("start_lap_no_hold", 0);
        sb_check(state);
        sb_check(lap_hold);
        press(BS);
        sb_push("resume2_state", RUN);
        sb_check(state);

        // 5: reset ignored in RUN; from PAUSE clears with one fsm_reset pulse
        press(BR);
        sb_push("run_reset_ignored", RUN);
        sb_push("run_reset_no_pulse", 0);
        sb_check(state);
        sb_check(fsm_reset);
        press(BS);
        sb_push("pause2_state", PAUSE);
        sb_check(state);
        pulse(BR);
        step();
        sb_push("clr_not_yet_state", PAUSE);
        sb_push("clr_not_yet_pulse", 0);
        sb_check(state);
        sb_check(fsm_reset);
        step();
        sb_push("clr_state", IDLE);
        sb_push("clr_pulse", 1);
        sb_push("clr_valid", 0);
        sb_check(state);
        sb_check(fsm_reset);
        sb_check(valid);
        step();
        sb_push("clr_pulse_end", 0);
        sb_push("clr_state_hold", IDLE);
        sb_check(fsm_reset);
        sb_check(state);
        press(BS);
        sb_push("post_clr_valid_c1", 0);
        sb_push("post_clr_valid_c2", 0);
        sb_push("post_clr_valid_c3", 0);
        sb_push("post_clr_valid_c4", 1);
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) step();
            sb_check(valid);
        end

        // 6: start and reset together in PAUSE: reset wins
        press(BS);
        sb_push("pause3_state", PAUSE);
        sb_check(state);
        btn_start = 1'b1;
        btn_reset = 1'b1;
        step();
        btn_start = 1'b0;
        btn_reset = 1'b0;
        step();
        step();
        sb_push("start_reset_coincide", IDLE);
        sb_push("start_reset_pulse", 1);
        sb_check(state);
        sb_check(fsm_reset);

        // held start for 50 cycles: a single transition
        btn_start = 1'b1;
        repeat (3) step();
        sb_push("held_first", RUN);
        sb_check(state);
        mism = 0;
        repeat (47) begin
            step();
            if (state !== RUN) mism++;
        end
        sb_push("held_single_transition", 0);
        sb_check(mism);
        btn_start = 1'b0;
        repeat (3) step();
        sb_push("held_release", RUN);
        sb_check(state);

        // rst mid-run drops a pending button edge
        pulse(BS);
        rst = 1'b0;
        step();
        sb_push("midrun_rst_state", IDLE);
        sb_push("midrun_rst_valid", 0);
        sb_check(state);
        sb_check(valid);
        rst = 1'b1;
        repeat (5) step();
        sb_push("pending_edge_lost", IDLE);
        sb_check(state);

        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
